ppu_loopy_registers: RTL and testbench

- Owns the PPU internal scroll/address state: v (current VRAM address), t (temporary address), fine X and the write toggle w.
- Writer side: applies CPU writes to PPUCTRL, PPUSCROLL and PPUADDR, PPUSTATUS read side-effects, and PPUDATA auto-increment.
- Also applies the renderer's coarse-X increment, Y increment and t→v copy strobes.
- Sits between the CPU register decode and the background fetch pipeline, which consumes o_v and o_fine_x.

---
 rtl/ppu_loopy_pkg.sv | 20 ++
 rtl/ppu_loopy_registers_increment_y.sv | 27 ++
 rtl/ppu_loopy_registers.sv | 141 ++++++++++++++
 tb/tb_ppu_loopy_registers.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/ppu_loopy_pkg.sv
// Shared constants for the PPU loopy scroll/address registers: CPU register
// indices and the bit positions of the v/t address fields.
package ppu_loopy_pkg;

  localparam logic [2:0] REG_PPUCTRL   = 3'd0;
  localparam logic [2:0] REG_PPUSTATUS = 3'd2;
  localparam logic [2:0] REG_PPUSCROLL = 3'd5;
  localparam logic [2:0] REG_PPUADDR   = 3'd6;
  localparam logic [2:0] REG_PPUDATA   = 3'd7;

  localparam int unsigned CX_LSB = 0;
  localparam int unsigned CX_MSB = 4;
  localparam int unsigned CY_LSB = 5;
  localparam int unsigned CY_MSB = 9;
  localparam int unsigned NT_LSB = 10;
  localparam int unsigned NT_MSB = 11;
  localparam int unsigned FY_LSB = 12;
  localparam int unsigned FY_MSB = 14;

endpackage

// File: rtl/ppu_loopy_registers_increment_y.sv
// Combinational Y increment of a loopy address: fine Y, then coarse Y with
// the row-29 nametable wrap and the row-31 attribute-area wrap.
module ppu_loopy_increment_y
  import ppu_loopy_pkg::*;
(
  input  logic [14:0] v_cur,
  output logic [14:0] v_next
);

  always_comb begin
    v_next = v_cur;
    if (v_cur[FY_MSB:FY_LSB] != 3'd7) begin
      v_next[FY_MSB:FY_LSB] = v_cur[FY_MSB:FY_LSB] + 3'd1;
    end else begin
      v_next[FY_MSB:FY_LSB] = '0;
      case (v_cur[CY_MSB:CY_LSB])
        5'd29: begin
          v_next[CY_MSB:CY_LSB] = '0;
          v_next[NT_MSB]        = ~v_cur[NT_MSB];
        end
        5'd31:   v_next[CY_MSB:CY_LSB] = '0;
        default: v_next[CY_MSB:CY_LSB] = v_cur[CY_MSB:CY_LSB] + 5'd1;
      endcase
    end
  end

endmodule

// File: rtl/ppu_loopy_registers.sv
// PPU internal scroll/address state (v, t, fine X, write toggle) updated by
// CPU register accesses and renderer increment/copy strobes.
module ppu_loopy_registers
  import ppu_loopy_pkg::*;
#(
  parameter bit GLITCH_2007_INC = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [2:0]  i_rs,
  input  logic [7:0]  i_data,
  input  logic        i_reg_write,
  input  logic        i_reg_read,
  input  logic        i_rendering_enabled,
  input  logic        i_inc_x,
  input  logic        i_inc_y,
  input  logic        i_copy_x,
  input  logic        i_copy_y,
  output logic [14:0] o_v,
  output logic [14:0] o_t,
  output logic [2:0]  o_fine_x,
  output logic        o_w,
  output logic        o_inc32
);

  logic [14:0] v_q, t_q, v_d, t_d;
  logic [2:0]  fx_q, fx_d;
  logic        w_q, w_d, inc32_q, inc32_d;
  logic        data_acc, addr_load;
  logic [14:0] v_x, v_y, v_rend;

  assign data_acc = (i_reg_write || i_reg_read) && (i_rs == REG_PPUDATA);

  // X stage feeds the single Y incrementer, so a rendering-time PPUDATA
  // access yields incy(incx(v)) without a second incrementer.
  always_comb begin
    v_x = v_q;
    if (i_rendering_enabled) begin
      if (data_acc || (i_inc_x && !i_copy_x)) begin
        if (v_q[CX_MSB:CX_LSB] == 5'd31) begin
          v_x[CX_MSB:CX_LSB] = '0;
          v_x[NT_LSB]        = ~v_q[NT_LSB];
        end else begin
          v_x[CX_MSB:CX_LSB] = v_q[CX_MSB:CX_LSB] + 5'd1;
        end
      end else if (i_copy_x) begin
        v_x[NT_LSB]        = t_q[NT_LSB];
        v_x[CX_MSB:CX_LSB] = t_q[CX_MSB:CX_LSB];
      end
    end
  end

  ppu_loopy_increment_y u_inc_y (
    .v_cur  (v_x),
    .v_next (v_y)
  );

  always_comb begin
    v_rend = v_x;
    if (i_rendering_enabled) begin
      if (i_copy_y) begin
        v_rend[FY_MSB:NT_MSB] = t_q[FY_MSB:NT_MSB];
        v_rend[CY_MSB:CY_LSB] = t_q[CY_MSB:CY_LSB];
      end else if (i_inc_y) begin
        v_rend = v_y;
      end
    end
  end

  always_comb begin
    t_d       = t_q;
    fx_d      = fx_q;
    w_d       = w_q;
    inc32_d   = inc32_q;
    addr_load = 1'b0;
    if (i_reg_write) begin
      case (i_rs)
        REG_PPUCTRL: begin
          t_d[NT_MSB:NT_LSB] = i_data[1:0];
          inc32_d            = i_data[2];
        end
        REG_PPUSCROLL: begin
          if (!w_q) begin
            t_d[CX_MSB:CX_LSB] = i_data[7:3];
            fx_d               = i_data[2:0];
            w_d                = 1'b1;
          end else begin
            t_d[FY_MSB:FY_LSB] = i_data[2:0];
            t_d[CY_MSB:CY_LSB] = i_data[7:3];
            w_d                = 1'b0;
          end
        end
        REG_PPUADDR: begin
          if (!w_q) begin
            t_d[13:8] = i_data[5:0];
            t_d[14]   = 1'b0;
            w_d       = 1'b1;
          end else begin
            t_d[7:0]  = i_data;
            w_d       = 1'b0;
            addr_load = 1'b1;
          end
        end
        default: ;
      endcase
    end
    if (i_reg_read && (i_rs == REG_PPUSTATUS)) w_d = 1'b0;

    if (addr_load) begin
      v_d = t_d;
    end else if (data_acc) begin
      if (i_rendering_enabled && GLITCH_2007_INC) v_d = v_y;
      else v_d = v_q + (inc32_q ? 15'd32 : 15'd1);
    end else begin
      v_d = v_rend;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      v_q     <= '0;
      t_q     <= '0;
      fx_q    <= '0;
      w_q     <= 1'b0;
      inc32_q <= 1'b0;
    end else begin
      v_q     <= v_d;
      t_q     <= t_d;
      fx_q    <= fx_d;
      w_q     <= w_d;
      inc32_q <= inc32_d;
    end
  end

  assign o_v      = v_q;
  assign o_t      = t_q;
  assign o_fine_x = fx_q;
  assign o_w      = w_q;
  assign o_inc32  = inc32_q;

endmodule

// File: tb/tb_ppu_loopy_registers.sv
// Self-checking bench for ppu_loopy_registers: vector table with queued
// expectations, plus hand-written reset sequences.
module tb_ppu_loopy_registers;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  rs = '0;
  logic [7:0]  data = '0;
  logic        reg_write = 1'b0, reg_read = 1'b0, ren = 1'b0;
  logic        inc_x = 1'b0, inc_y = 1'b0, copy_x = 1'b0, copy_y = 1'b0;
  logic [14:0] v, t;
  logic [2:0]  fine_x;
  logic        w, inc32;

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;

  always #5 clk = ~clk;

  ppu_loopy_registers #(.GLITCH_2007_INC(1'b1)) dut (
    .i_clk               (clk),
    .i_reset_n           (rst_n),
    .i_rs                (rs),
    .i_data              (data),
    .i_reg_write         (reg_write),
    .i_reg_read          (reg_read),
    .i_rendering_enabled (ren),
    .i_inc_x             (inc_x),
    .i_inc_y             (inc_y),
    .i_copy_x            (copy_x),
    .i_copy_y            (copy_y),
    .o_v                 (v),
    .o_t                 (t),
    .o_fine_x            (fine_x),
    .o_w                 (w),
    .o_inc32             (inc32)
  );

  always @(posedge clk) begin
    assert (!(reg_write && reg_read)) else $error("write and read strobes both high");
  end

  typedef struct packed {
    logic [14:0] v;
    logic [14:0] t;
    logic [2:0]  fx;
    logic        w;
    logic        i32;
  } state_t;

  typedef struct {
    logic [2:0] rs;
    logic [7:0] d;
    logic       wr;
    logic       rd;
    logic       ren;
    logic [3:0] strb;  // {inc_x, inc_y, copy_x, copy_y}
    state_t     exp;
  } vec_t;

  vec_t   vecs[$];
  state_t exp_q[$];

  function automatic vec_t mk(input logic [2:0] r, input logic [7:0] d, input logic wr,
                              input logic rd, input logic re, input logic [3:0] s,
                              input logic [14:0] ev, input logic [14:0] et,
                              input logic [2:0] efx, input logic ew, input logic ei);
    vec_t x;
    x.rs = r; x.d = d; x.wr = wr; x.rd = rd; x.ren = re; x.strb = s;
    x.exp = '{v: ev, t: et, fx: efx, w: ew, i32: ei};
    return x;
  endfunction

  task automatic check(input string name, input state_t exp);
    state_t act;
    act = '{v: v, t: t, fx: fine_x, w: w, i32: inc32};
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got v=%h t=%h fx=%0d w=%0d inc32=%0d, want v=%h t=%h fx=%0d w=%0d inc32=%0d",
                  name, act.v, act.t, act.fx, act.w, act.i32,
                  exp.v, exp.t, exp.fx, exp.w, exp.i32);
  endtask

  task automatic drive(input logic [2:0] r, input logic [7:0] d, input logic wr,
                       input logic rd, input logic re, input logic [3:0] s);
    @(negedge clk);
    rs = r; data = d; reg_write = wr; reg_read = rd; ren = re;
    {inc_x, inc_y, copy_x, copy_y} = s;
    @(posedge clk);
    #1;
    reg_write = 1'b0; reg_read = 1'b0; {inc_x, inc_y, copy_x, copy_y} = '0;
  endtask

  initial begin
    state_t e;
    vecs.push_back(mk(5, 8'h7D, 1, 0, 0, 4'h0, 15'h0000, 15'h000F, 5, 1, 0));
    vecs.push_back(mk(5, 8'h5E, 1, 0, 0, 4'h0, 15'h0000, 15'h616F, 5, 0, 0));
    vecs.push_back(mk(6, 8'h3F, 1, 0, 0, 4'h0, 15'h0000, 15'h3F6F, 5, 1, 0));
    vecs.push_back(mk(6, 8'h10, 1, 0, 0, 4'h0, 15'h3F10, 15'h3F10, 5, 0, 0));
    vecs.push_back(mk(6, 8'hFF, 1, 0, 0, 4'h0, 15'h3F10, 15'h3F10, 5, 1, 0));
    vecs.push_back(mk(2, 8'h00, 0, 1, 0, 4'h0, 15'h3F10, 15'h3F10, 5, 0, 0));
    vecs.push_back(mk(5, 8'h7D, 1, 0, 0, 4'h0, 15'h3F10, 15'h3F0F, 5, 1, 0));
    vecs.push_back(mk(2, 8'h00, 0, 1, 0, 4'h0, 15'h3F10, 15'h3F0F, 5, 0, 0));
    vecs.push_back(mk(5, 8'h5E, 1, 0, 0, 4'h0, 15'h3F10, 15'h3F0B, 6, 1, 0));
    vecs.push_back(mk(2, 8'h00, 0, 1, 0, 4'h0, 15'h3F10, 15'h3F0B, 6, 0, 0));
    vecs.push_back(mk(0, 8'h04, 1, 0, 0, 4'h0, 15'h3F10, 15'h330B, 6, 0, 1));
    vecs.push_back(mk(7, 8'h00, 0, 1, 0, 4'h0, 15'h3F30, 15'h330B, 6, 0, 1));
    vecs.push_back(mk(7, 8'h55, 1, 0, 0, 4'h8, 15'h3F50, 15'h330B, 6, 0, 1));
    vecs.push_back(mk(0, 8'h00, 1, 0, 0, 4'h0, 15'h3F50, 15'h330B, 6, 0, 0));
    vecs.push_back(mk(7, 8'h00, 0, 1, 0, 4'h0, 15'h3F51, 15'h330B, 6, 0, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 4'hF, 15'h3F51, 15'h330B, 6, 0, 0));
    vecs.push_back(mk(0, 8'h07, 1, 0, 0, 4'h0, 15'h3F51, 15'h3F0B, 6, 0, 1));
    vecs.push_back(mk(5, 8'h80, 1, 0, 0, 4'h0, 15'h3F51, 15'h3F10, 0, 1, 1));
    vecs.push_back(mk(5, 8'hFF, 1, 0, 0, 4'h0, 15'h3F51, 15'h7FF0, 0, 0, 1));
    vecs.push_back(mk(0, 8'h00, 0, 0, 1, 4'h3, 15'h7FF0, 15'h7FF0, 0, 0, 1));
    vecs.push_back(mk(7, 8'h00, 0, 1, 0, 4'h8, 15'h0010, 15'h7FF0, 0, 0, 1));
    vecs.push_back(mk(6, 8'h00, 1, 0, 0, 4'h0, 15'h0010, 15'h00F0, 0, 1, 1));
    vecs.push_back(mk(6, 8'h1F, 1, 0, 0, 4'h0, 15'h001F, 15'h001F, 0, 0, 1));
    vecs.push_back(mk(0, 8'h00, 0, 0, 1, 4'h8, 15'h0400, 15'h001F, 0, 0, 1));
    vecs.push_back(mk(0, 8'h00, 0, 0, 1, 4'h8, 15'h0401, 15'h001F, 0, 0, 1));
    vecs.push_back(mk(0, 8'h00, 1, 0, 0, 4'h0, 15'h0401, 15'h001F, 0, 0, 0));
    vecs.push_back(mk(5, 8'h00, 1, 0, 0, 4'h0, 15'h0401, 15'h0000, 0, 1, 0));
    vecs.push_back(mk(5, 8'hEF, 1, 0, 0, 4'h0, 15'h0401, 15'h73A0, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 1, 4'h3, 15'h73A0, 15'h73A0, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 1, 4'h4, 15'h0800, 15'h73A0, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 1, 4'hC, 15'h1801, 15'h73A0, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 1, 4'hD, 15'h73A2, 15'h73A0, 0, 0, 0));
    vecs.push_back(mk(5, 8'h00, 1, 0, 0, 4'h0, 15'h73A2, 15'h73A0, 0, 1, 0));
    vecs.push_back(mk(5, 8'hFF, 1, 0, 0, 4'h0, 15'h73A2, 15'h73E0, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 1, 4'h3, 15'h73E0, 15'h73E0, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 1, 4'h4, 15'h0000, 15'h73E0, 0, 0, 0));
    vecs.push_back(mk(7, 8'h00, 0, 1, 1, 4'h0, 15'h1001, 15'h73E0, 0, 0, 0));
    vecs.push_back(mk(7, 8'h00, 1, 0, 1, 4'h2, 15'h2002, 15'h73E0, 0, 0, 0));
    vecs.push_back(mk(6, 8'h15, 1, 0, 1, 4'h0, 15'h2002, 15'h15E0, 0, 1, 0));
    vecs.push_back(mk(6, 8'h2A, 1, 0, 1, 4'h2, 15'h152A, 15'h152A, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 1, 4'h8, 15'h152B, 15'h152A, 0, 0, 0));
    vecs.push_back(mk(5, 8'hF8, 1, 0, 1, 4'h2, 15'h152A, 15'h153F, 0, 1, 0));
    vecs.push_back(mk(2, 8'h00, 0, 1, 0, 4'h0, 15'h152A, 15'h153F, 0, 0, 0));

    // Power-on reset
    repeat (3) @(posedge clk);
    #1 check("reset_state", '0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      exp_q.push_back(vecs[i].exp);
      drive(vecs[i].rs, vecs[i].d, vecs[i].wr, vecs[i].rd, vecs[i].ren, vecs[i].strb);
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL vec%0d: scoreboard empty, got none, want one entry", i);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("vec%0d", i), e);
      end
    end

    // Asynchronous reset with w=1 mid-sequence
    drive(6, 8'h12, 1, 0, 0, 4'h0);
    check("addr_first_before_reset", '{v: 15'h152A, t: 15'h123F, fx: 3'd0, w: 1'b1, i32: 1'b0});
    #2 rst_n = 1'b0;
    #1 check("async_reset_immediate", '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check("after_reset_release", '0);
    drive(5, 8'h7D, 1, 0, 0, 4'h0);
    check("scroll_first_after_reset", '{v: 15'h0000, t: 15'h000F, fx: 3'd5, w: 1'b1, i32: 1'b0});

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
